// File: rtl/sbox_share_arbiter_if.sv
// Bundle for the shared S-box arbiter: two requester channels, the S-box port,
// the two response channels and the in-flight indicator.
interface sbox_share_arbiter_if;
    // Handshake: a request word transfers in the cycle where X_req_valid and
    // X_req_ready are both high. Ready is a same-cycle grant and never rises
    // without valid. Responses are plain valid pulses that the requester must
    // always take.
    logic        ke_req_valid;
    logic [31:0] ke_req_data;
    logic        ke_req_ready;
    logic        dp_req_valid;
    logic [31:0] dp_req_data;
    logic        dp_req_ready;
    logic        sb_in_valid;
    logic [31:0] sb_in_data;
    logic [31:0] sb_out_data;
    logic        ke_rsp_valid;
    logic [31:0] ke_rsp_data;
    logic        dp_rsp_valid;
    logic [31:0] dp_rsp_data;
    logic        busy;

    modport master (
        output ke_req_valid, ke_req_data, dp_req_valid, dp_req_data, sb_out_data,
        input  ke_req_ready, dp_req_ready, sb_in_valid, sb_in_data,
        input  ke_rsp_valid, ke_rsp_data, dp_rsp_valid, dp_rsp_data, busy
    );

    modport slave (
        input  ke_req_valid, ke_req_data, dp_req_valid, dp_req_data, sb_out_data,
        output ke_req_ready, dp_req_ready, sb_in_valid, sb_in_data,
        output ke_rsp_valid, ke_rsp_data, dp_rsp_valid, dp_rsp_data, busy
    );
endinterface

// File: rtl/sbox_share_arbiter.sv
// Shares one SB_LAT-cycle S-box between key expansion (KE) and the round datapath (DP).
// Define SBOX_KE_PRIORITY_EN for strict KE priority; default is round-robin on contention.
module sbox_share_arbiter #(
    parameter int SB_LAT = 3
) (
    input logic           clk,
    input logic           rst_n,
    sbox_share_arbiter_if.slave bus
);

    localparam logic OWNER_KE = 1'b0;
    localparam logic OWNER_DP = 1'b1;

    logic              grant_ke;
    logic              grant_dp;
    logic              grant_any;
    logic [SB_LAT-1:0] tag_valid;
    logic [SB_LAT-1:0] tag_owner;

`ifdef SBOX_KE_PRIORITY_EN
    always_comb begin
        grant_ke = rst_n & bus.ke_req_valid;
        grant_dp = rst_n & bus.dp_req_valid & ~bus.ke_req_valid;
    end
`else
    logic last_grant;

    always_comb begin
        grant_ke = 1'b0;
        grant_dp = 1'b0;
        if (bus.ke_req_valid && bus.dp_req_valid) begin
            grant_ke = (last_grant == OWNER_DP);
            grant_dp = (last_grant == OWNER_KE);
        end else begin
            grant_ke = bus.ke_req_valid;
            grant_dp = bus.dp_req_valid;
        end
        grant_ke = grant_ke & rst_n;
        grant_dp = grant_dp & rst_n;
    end

    // Reset to DP so the first contention after reset goes to KE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= OWNER_DP;
        end else if (grant_ke) begin
            last_grant <= OWNER_KE;
        end else if (grant_dp) begin
            last_grant <= OWNER_DP;
        end
    end
`endif

    assign grant_any = grant_ke | grant_dp;

    // Tag pipeline mirrors the S-box latency; stage SB_LAT-1 lines up with sb_out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= '0;
            tag_owner <= '0;
        end else begin
            tag_valid[0] <= grant_any;
            tag_owner[0] <= grant_dp ? OWNER_DP : OWNER_KE;
            for (int i = 1; i < SB_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_owner[i] <= tag_owner[i-1];
            end
        end
    end

    always_comb begin
        bus.ke_req_ready = grant_ke;
        bus.dp_req_ready = grant_dp;
        bus.sb_in_valid  = grant_any;
        bus.sb_in_data   = '0;
        if (grant_ke) begin
            bus.sb_in_data = bus.ke_req_data;
        end else if (grant_dp) begin
            bus.sb_in_data = bus.dp_req_data;
        end
    end

    always_comb begin
        bus.ke_rsp_valid = tag_valid[SB_LAT-1] & (tag_owner[SB_LAT-1] == OWNER_KE);
        bus.dp_rsp_valid = tag_valid[SB_LAT-1] & (tag_owner[SB_LAT-1] == OWNER_DP);
        bus.ke_rsp_data  = bus.ke_rsp_valid ? bus.sb_out_data : 32'h0;
        bus.dp_rsp_data  = bus.dp_rsp_valid ? bus.sb_out_data : 32'h0;
        // A word being issued this cycle already counts as in flight.
        bus.busy         = (|tag_valid) | grant_any;
    end

endmodule

// File: tb/tb_sbox_share_arbiter.sv
// Bench for sbox_share_arbiter: AES S-box pipeline stand-in, directed scenarios and a
// randomized run checked against a queue-based reference model.
module tb_sbox_share_arbiter;
  localparam int SB_LAT = 3;
  localparam int N_RAND = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  logic [64:0] exp_q[$];  // {owner dp, due cycle, data}

  always #5 clk = ~clk;

  sbox_share_arbiter_if bus();

  sbox_share_arbiter #(.SB_LAT(SB_LAT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  logic [7:0] sbox_tab [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // Shared S-box stand-in: SB_LAT-stage pipeline of byte substitutions.
  logic [31:0] sb_pipe [SB_LAT];
  always @(posedge clk) begin
    sb_pipe[0] <= sub_word(bus.sb_in_data);
    for (int i = 1; i < SB_LAT; i++) sb_pipe[i] <= sb_pipe[i-1];
  end
  assign bus.sb_out_data = sb_pipe[SB_LAT-1];

  task automatic drive(input logic kv, input logic [31:0] kd, input logic dv, input logic [31:0] dd);
    bus.ke_req_valid = kv;
    bus.ke_req_data  = kd;
    bus.dp_req_valid = dv;
    bus.dp_req_data  = dd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0] flags;
    #1 rst_n = 1'b0;
    drive(1'b1, 32'hdeadbeef, 1'b1, 32'h01234567);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      flags = {bus.ke_req_ready, bus.dp_req_ready, bus.sb_in_valid,
               bus.ke_rsp_valid, bus.dp_rsp_valid, bus.busy};
      n_tests++;
      if (flags !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_flags cyc=%0d got=%b exp=000000", i, flags);
      end
      n_tests++;
      if ({bus.sb_in_data, bus.ke_rsp_data, bus.dp_rsp_data} !== 96'h0) begin
        n_fail++;
        $display("FAIL reset_data cyc=%0d sb=%h ke=%h dp=%h exp=0", i,
                 bus.sb_in_data, bus.ke_rsp_data, bus.dp_rsp_data);
      end
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic test_ke_only();
    logic [5:0] flags, exp_flags;
    logic [31:0] exp_sbd, exp_kd;
    for (int i = 0; i <= SB_LAT + 1; i++) begin
      if (i == 0) drive(1'b1, 32'h00010203, 1'b0, 32'h0);
      else drive(1'b0, 32'h0, 1'b0, 32'h0);
      exp_flags = {i == 0, 1'b0, i == 0, i == SB_LAT, 1'b0, i <= SB_LAT};
      exp_sbd = (i == 0) ? 32'h00010203 : 32'h0;
      exp_kd = (i == SB_LAT) ? 32'h637c777b : 32'h0;
      @(negedge clk);
      flags = {bus.ke_req_ready, bus.dp_req_ready, bus.sb_in_valid,
               bus.ke_rsp_valid, bus.dp_rsp_valid, bus.busy};
      n_tests++;
      if (flags !== exp_flags) begin
        n_fail++;
        $display("FAIL ke_only_flags cyc=%0d got=%b exp=%b", i, flags, exp_flags);
      end
      n_tests++;
      if (bus.sb_in_data !== exp_sbd || bus.ke_rsp_data !== exp_kd || bus.dp_rsp_data !== 32'h0) begin
        n_fail++;
        $display("FAIL ke_only_data cyc=%0d sb=%h/%h ke=%h/%h dp=%h/0", i, bus.sb_in_data, exp_sbd,
                 bus.ke_rsp_data, exp_kd, bus.dp_rsp_data);
      end
      next_cycle();
    end
  endtask

  // Both requesters are held for n_both cycles; DP alone stays one cycle longer when n_dp > n_both.
  task automatic test_contention_case(input string name, input int n_ke, input int n_dp,
                                      input logic [31:0] kd, input logic [31:0] dd,
                                      input logic [7:0] ke_mask);
    logic [5:0] flags, exp_flags;
    logic [31:0] exp_sbd, exp_kd, exp_dd;
    logic g_ke, g_dp, r_ke, r_dp;
    int n_issue;
    n_issue = (n_ke > n_dp) ? n_ke : n_dp;
    for (int i = 0; i < n_issue + SB_LAT + 1; i++) begin
      drive(i < n_ke, kd, i < n_dp, dd);
      g_ke = (i < n_issue) && ke_mask[i];
      g_dp = (i < n_issue) && !ke_mask[i];
      r_ke = (i >= SB_LAT) && (i - SB_LAT < n_issue) && ke_mask[i-SB_LAT];
      r_dp = (i >= SB_LAT) && (i - SB_LAT < n_issue) && !ke_mask[i-SB_LAT];
      exp_flags = {g_ke, g_dp, g_ke | g_dp, r_ke, r_dp, i < n_issue + SB_LAT};
      exp_sbd = g_ke ? kd : (g_dp ? dd : 32'h0);
      exp_kd = r_ke ? sub_word(kd) : 32'h0;
      exp_dd = r_dp ? sub_word(dd) : 32'h0;
      @(negedge clk);
      flags = {bus.ke_req_ready, bus.dp_req_ready, bus.sb_in_valid,
               bus.ke_rsp_valid, bus.dp_rsp_valid, bus.busy};
      n_tests++;
      if (flags !== exp_flags) begin
        n_fail++;
        $display("FAIL %s_flags cyc=%0d got=%b exp=%b", name, i, flags, exp_flags);
      end
      n_tests++;
      if (bus.sb_in_data !== exp_sbd || bus.ke_rsp_data !== exp_kd || bus.dp_rsp_data !== exp_dd) begin
        n_fail++;
        $display("FAIL %s_data cyc=%0d sb=%h/%h ke=%h/%h dp=%h/%h", name, i, bus.sb_in_data, exp_sbd,
                 bus.ke_rsp_data, exp_kd, bus.dp_rsp_data, exp_dd);
      end
      next_cycle();
    end
  endtask

  task automatic test_mid_reset();
    logic [5:0] flags;
    drive(1'b0, 32'h0, 1'b1, 32'h11223344);
    @(negedge clk);
    n_tests++;
    if (bus.dp_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_issue got=%b exp=1", bus.dp_req_ready);
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      flags = {bus.ke_req_ready, bus.dp_req_ready, bus.sb_in_valid,
               bus.ke_rsp_valid, bus.dp_rsp_valid, bus.busy};
      n_tests++;
      if (flags !== 6'b0 || bus.dp_rsp_data !== 32'h0) begin
        n_fail++;
        $display("FAIL mid_reset_flush cyc=T+%0d flags=%b dp=%h exp=0", i, flags, bus.dp_rsp_data);
      end
      next_cycle();
      rst_n = 1'b1;
    end
    drive(1'b1, 32'haabbccdd, 1'b1, 32'h55667788);
    @(negedge clk);
    n_tests++;
    if ({bus.ke_req_ready, bus.dp_req_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_reset_next_grant got=%b exp=10", {bus.ke_req_ready, bus.dp_req_ready});
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < SB_LAT + 1; i++) next_cycle();
  endtask

  task automatic test_idle();
    logic [5:0] flags;
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      flags = {bus.ke_req_ready, bus.dp_req_ready, bus.sb_in_valid,
               bus.ke_rsp_valid, bus.dp_rsp_valid, bus.busy};
      n_tests++;
      if (flags !== 6'b0 || bus.sb_in_data !== 32'h0 || bus.ke_rsp_data !== 32'h0 || bus.dp_rsp_data !== 32'h0) begin
        n_fail++;
        $display("FAIL idle cyc=%0d flags=%b sb=%h exp=0", i, flags, bus.sb_in_data);
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    logic kv, dv, g_ke, g_dp, e_kv, e_dv, e_busy;
    logic [31:0] kd, dd, e_sbd, e_kd, e_dd;
    logic [64:0] ent;
`ifndef SBOX_KE_PRIORITY_EN
    logic last_was_ke;
    last_was_ke = 1'b0;
`endif
    exp_q.delete();
    for (int c = 0; c < N_RAND + SB_LAT + 2; c++) begin
      kv = (c < N_RAND) && ($urandom_range(0, 3) != 0);
      dv = (c < N_RAND) && ($urandom_range(0, 3) != 0);
      kd = $urandom;
      dd = $urandom;
      drive(kv, kd, dv, dd);
`ifdef SBOX_KE_PRIORITY_EN
      g_ke = kv;
      g_dp = dv && !kv;
`else
      if (kv && dv) g_ke = !last_was_ke;
      else g_ke = kv;
      g_dp = dv && !g_ke;
      if (g_ke || g_dp) last_was_ke = g_ke;
`endif
      e_sbd = g_ke ? kd : (g_dp ? dd : 32'h0);
      e_busy = g_ke || g_dp || (exp_q.size() != 0);
      e_kv = 1'b0; e_dv = 1'b0; e_kd = 32'h0; e_dd = 32'h0;
      if (exp_q.size() != 0 && exp_q[0][63:32] == 32'(c)) begin
        ent = exp_q.pop_front();
        if (ent[64]) begin e_dv = 1'b1; e_dd = ent[31:0]; end
        else begin e_kv = 1'b1; e_kd = ent[31:0]; end
      end
      if (g_ke || g_dp) exp_q.push_back({g_dp, 32'(c + SB_LAT), sub_word(e_sbd)});
      @(negedge clk);
      n_tests++;
      if ({bus.ke_req_ready, bus.dp_req_ready, bus.sb_in_valid} !== {g_ke, g_dp, g_ke | g_dp}) begin
        n_fail++;
        $display("FAIL rand_grant cyc=%0d got=%b exp=%b", c,
                 {bus.ke_req_ready, bus.dp_req_ready, bus.sb_in_valid}, {g_ke, g_dp, g_ke | g_dp});
      end
      n_tests++;
      if (bus.sb_in_data !== e_sbd) begin
        n_fail++;
        $display("FAIL rand_sb_in cyc=%0d got=%h exp=%h", c, bus.sb_in_data, e_sbd);
      end
      n_tests++;
      if ({bus.ke_rsp_valid, bus.dp_rsp_valid, bus.busy} !== {e_kv, e_dv, e_busy}) begin
        n_fail++;
        $display("FAIL rand_rsp_flags cyc=%0d got=%b exp=%b", c,
                 {bus.ke_rsp_valid, bus.dp_rsp_valid, bus.busy}, {e_kv, e_dv, e_busy});
      end
      n_tests++;
      if (bus.ke_rsp_data !== e_kd || bus.dp_rsp_data !== e_dd) begin
        n_fail++;
        $display("FAIL rand_rsp_data cyc=%0d ke=%h/%h dp=%h/%h", c, bus.ke_rsp_data, e_kd,
                 bus.dp_rsp_data, e_dd);
      end
      next_cycle();
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain left=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    test_reset();
    test_ke_only();
    apply_reset();
`ifdef SBOX_KE_PRIORITY_EN
    // KE held 3 cycles, DP 4: KE,KE,KE then DP.
    test_contention_case("priority", 3, 4, 32'h01010101, 32'h00000000, 8'b0000_0111);
`else
    // Both held 4 cycles: KE,DP,KE,DP.
    test_contention_case("contention", 4, 4, 32'h53535353, 32'h00000000, 8'b0000_0101);
`endif
    test_mid_reset();
    test_idle();
    apply_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sbox_share_arbiter.md
SBOX_SHARE_ARBITER -- requirements
Module: sbox_share_arbiter

Interface
REQ-001 SHALL have parameter: SB_LAT, 3, fixed pipeline latency in cycles of the shared 4-byte S-box (legal 1..8).
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: ke_req_valid  in  1  key-expansion requester has a word to substitute.
REQ-005 SHALL have port: ke_req_data  in  32  key-expansion word (4 independent bytes).
REQ-006 SHALL have port: ke_req_ready  out  1  key-expansion word accepted this cycle.
REQ-007 SHALL have port: dp_req_valid  in  1  round-datapath (SubBytes) requester has a column.
REQ-008 SHALL have port: dp_req_data  in  32  round-datapath column.
REQ-009 SHALL have port: dp_req_ready  out  1  round-datapath column accepted this cycle.
REQ-010 SHALL have port: sb_in_valid  out  1  word issued to shared S-box this cycle.
REQ-011 SHALL have port: sb_in_data  out  32  word issued to shared S-box.
REQ-012 SHALL have port: sb_out_data  in  32  S-box result, valid SB_LAT cycles after issue.
REQ-013 SHALL have port: ke_rsp_valid / ke_rsp_data  out  1/32  substituted word returned to key expansion.
REQ-014 SHALL have port: dp_rsp_valid / dp_rsp_data  out  1/32  substituted column returned to round datapath.
REQ-015 SHALL have port: busy  out  1  at least one issued word still in flight.

Function
REQ-016 SHALL accept at most one request per cycle; X_req_ready SHALL be high only in the cycle that requester is granted, and only when its valid is high.
REQ-017 SHALL grant the sole valid requester when only one is valid, regardless of history.
REQ-018 SHALL, when both valid, grant the requester not granted most recently (round-robin via 1-bit last_grant register, updated only on a grant).
REQ-019 SHALL drive sb_in_valid = grant and sb_in_data = granted requester's data combinationally in the grant cycle; sb_in_data SHALL be 0 when no grant.
REQ-020 SHALL hold an SB_LAT-deep shift register of {valid, owner} tags advancing every cycle; no stall, no backpressure.
REQ-021 SHALL assert exactly one of ke_rsp_valid / dp_rsp_valid exactly SB_LAT cycles after the grant, per the tag owner, for one cycle.
REQ-022 SHALL drive X_rsp_data = sb_out_data when X_rsp_valid is high, else 0.
REQ-023 SHALL sustain one issue per cycle; responses return in issue order; alternating contention yields KE,DP,KE,DP... back to back.
REQ-024 SHALL drive busy high whenever any tag valid bit is set.
REQ-025 Requesters SHALL always accept responses; no response-side handshake exists.

Reset
REQ-026 SHALL, on rst_n low, immediately clear all tags and set last_grant = DP (first contention after reset goes to KE).
REQ-027 SHALL hold all outputs at 0 (ready, sb_in_valid, rsp_valid, rsp_data, sb_in_data, busy) while rst_n is low.
REQ-028 SHALL discard in-flight words on mid-operation reset; no response emitted for them after release.

Configuration
REQ-029 With SBOX_KE_PRIORITY_EN defined, SHALL grant KE whenever ke_req_valid is high (strict priority; DP only when KE idle); last_grant unused.
REQ-030 Without SBOX_KE_PRIORITY_EN, SHALL use round-robin per REQ-018.

Verification (bench models S-box as SB_LAT-stage AES S-box pipeline)
REQ-031 Reset release, KE only, ke_req_data=0x00010203 at cycle T -> ke_req_ready=1 at T, ke_rsp_valid=1 at T+3, ke_rsp_data=0x637c777b, dp_rsp_valid stays 0.
REQ-032 Both valid continuously 4 cycles, KE=0x53535353, DP=0x00000000 -> grants KE,DP,KE,DP; responses 0xedededed,0x63636363,... at T+3..T+6; busy high T..T+6.
REQ-033 SBOX_KE_PRIORITY_EN defined, both valid 3 cycles then KE drops -> dp_req_ready low first 3 cycles, high 4th; DP response 3 cycles later.
REQ-034 Issue DP at T, assert rst_n low at T+1 for 1 cycle -> no dp_rsp_valid at T+3, busy 0 after reset, next contention grants KE.
REQ-035 No valid for 10 cycles -> all ready/rsp_valid/sb_in_valid/busy remain 0, sb_in_data=0.
